// File: rtl/mux_arbiter_2to1_16bit_pkg.sv
// Shared definitions for the 2-to-1 arbitrated 16-bit mux.
package mux_arbiter_2to1_16bit_pkg;

  localparam int unsigned DATA_WIDTH     = 16;
  localparam int unsigned PRIORITY_RR    = 0;
  localparam int unsigned PRIORITY_FIXED = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  // Winner index for a capture cycle; ties go to the non-last winner (RR) or to 0 (fixed).
  function automatic logic pick_winner(input logic req0, input logic req1,
                                       input logic last_grant, input logic fixed_prio);
    logic win;
    if (req0 && req1) begin
      win = fixed_prio ? 1'b0 : ~last_grant;
    end else begin
      win = req1;
    end
    return win;
  endfunction

endpackage

// File: rtl/mux_arbiter_2to1_16bit_if.sv
// Requester/consumer bus of the arbitrated mux.
interface mux_arbiter_2to1_16bit_if
  import mux_arbiter_2to1_16bit_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             out_ready;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             last_grant;

  // Environment side: requesters plus consumer.
  modport master (
    output req0, data0, req1, data1, out_ready,
    input  gnt0, gnt1, sel, out_data, out_valid, last_grant
  );

  // Arbiter side.
  modport slave (
    input  req0, data0, req1, data1, out_ready,
    output gnt0, gnt1, sel, out_data, out_valid, last_grant
  );
endinterface

// File: rtl/mux_arbiter_2to1_16bit_mux.sv
// Plain 2-to-1 datapath select.
module mux2_to_1_16bit
  import mux_arbiter_2to1_16bit_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             s0,
  output logic [WIDTH-1:0] y
);
  // s0 = 0 picks i0, s0 = 1 picks i1.
  assign y = s0 ? i1 : i0;
endmodule

// File: rtl/mux_arbiter_2to1_16bit.sv
// Two requesters share one mux; winner's word is registered and offered valid/ready.
module mux_arbiter_2to1_16bit
  import mux_arbiter_2to1_16bit_pkg::*;
#(
  parameter int unsigned WIDTH         = DATA_WIDTH,
  parameter int unsigned PRIORITY_MODE = PRIORITY_RR
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mux_arbiter_2to1_16bit_if.slave  bus
);

  state_t           r_state;
  logic [WIDTH-1:0] r_out_data;
  logic             r_last_grant;

  logic             w_fixed;
  logic             w_can_capture;
  logic             w_capture;
  logic             w_winner;
  logic             w_sel;
  logic [WIDTH-1:0] w_mux_out;

  assign w_fixed = (PRIORITY_MODE == PRIORITY_FIXED);

  // Arbitration: decide whether a word is taken this cycle and from whom.
  always_comb begin
    w_can_capture = (r_state == ST_IDLE) || ((r_state == ST_FULL) && bus.out_ready);
    w_capture     = rst_n && w_can_capture && (bus.req0 || bus.req1);
    w_winner      = pick_winner(bus.req0, bus.req1, r_last_grant, w_fixed);
    w_sel         = w_capture ? w_winner : r_last_grant;
  end

  mux2_to_1_16bit #(
    .WIDTH (WIDTH)
  ) u_mux (
    .i0 (bus.data0),
    .i1 (bus.data1),
    .s0 (w_sel),
    .y  (w_mux_out)
  );

  // State, output word and last winner; a capture also frees the slot in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_out_data   <= '0;
      r_last_grant <= 1'b1;
    end else if (w_capture) begin
      r_state      <= ST_FULL;
      r_out_data   <= w_mux_out;
      r_last_grant <= w_winner;
    end else if ((r_state == ST_FULL) && bus.out_ready) begin
      r_state      <= ST_IDLE;
    end
  end

  assign bus.gnt0       = w_capture && !w_winner;
  assign bus.gnt1       = w_capture && w_winner;
  assign bus.sel        = w_sel;
  assign bus.out_data   = r_out_data;
  assign bus.out_valid  = (r_state == ST_FULL);
  assign bus.last_grant = r_last_grant;

endmodule

// File: doc/mux_arbiter_2to1_16bit.md
Name: mux_arbiter_2to1_16bit

Overview:
- Shares one 16-bit datapath mux (2-to-1, select s0) between two requesters.
- Picks a requester with round-robin or fixed priority and drives the mux select.
- Captures the selected word into an output register and presents it to a single consumer with a valid/ready handshake.
- Sits in front of shared operand/result buses, e.g. the register-file write-back port, where two sources compete for one 16-bit path.

Parameters:
- WIDTH, 16, data width of each requester and of the output register.
- PRIORITY_MODE, 0, 0 = round-robin; 1 = fixed priority with requester 0 always winning ties.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk.
- req0  input  1  requester 0 has a word to send.
- data0  input  WIDTH  requester 0 data; held stable while req0=1 and gnt0=0.
- req1  input  1  requester 1 has a word to send.
- data1  input  WIDTH  requester 1 data; same stability rule.
- out_ready  input  1  consumer accepts out_data this cycle.
- gnt0  output  1  combinational; requester 0 word is captured at this edge.
- gnt1  output  1  combinational; requester 1 word is captured at this edge.
- sel  output  1  combinational mux select (0 = data0, 1 = data1); equals the winner when capturing, otherwise last_grant.
- out_data  output  WIDTH  registered captured word.
- out_valid  output  1  registered; out_data is valid.
- last_grant  output  1  registered index of the most recent winner.

Behaviour:
- Reset (rst_n=0 at the edge): out_valid=0, out_data=0, last_grant=1 (requester 0 wins the first tie), FSM=IDLE.
- gnt0/gnt1 are 0 whenever rst_n=0.
- FSM states:
  - IDLE (out_valid=0).
  - FULL (out_valid=1).
- can_capture = (state==IDLE) or (state==FULL and out_ready).
- Winner selection when can_capture:
  - Only req0 -> 0; only req1 -> 1.
  - Both: PRIORITY_MODE=0 -> the index not equal to last_grant; PRIORITY_MODE=1 -> 0.
- Capture: when can_capture and (req0|req1):
  - gnt of the winner =1 that cycle; sel = winner.
  - At the edge: out_data <= mux(data0, data1, sel); last_grant <= winner; state -> FULL.
- gnt0 and gnt1 are never both 1 (one-hot or zero).
- FULL with out_ready=0: out_data, out_valid and last_grant hold; no gnt.
- FULL with out_ready=1 and no req: state -> IDLE, out_valid -> 0; out_data holds its last value.
- FULL with out_ready=1 and a req: capture in the same cycle (back-to-back); out_valid stays 1, giving one word per cycle throughput.
- Latency: req to out_valid is 1 cycle when IDLE.
- A requester drops req only after seeing its gnt. A req withdrawn before gnt is legal and simply loses arbitration.
- Reset mid-operation: a word held in FULL is discarded; out_valid=0 on the next cycle; no gnt during reset.
- Starvation bound in round-robin mode: a continuously asserted req is granted within 2 captures.
- out_ready while IDLE is ignored.

Decomposition:
- Shared package (processor-wide defines): WIDTH default 16; state encodings IDLE=1'b0, FULL=1'b1; PRIORITY_RR=0, PRIORITY_FIXED=1.
- One sub-module: instantiate mux2_to_1_16bit for the datapath select (i0=data0, i1=data1, s0=sel).
- Arbitration logic, FSM and output register stay in the top module.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then release with no req -> out_valid=0, out_data=16'h0000, last_grant=1, gnt0=gnt1=0.
- Single request: req0=1, data0=16'd5, out_ready=1 -> gnt0=1 in cycle 0; out_valid=1 and out_data=5 in cycle 1; last_grant=0.
- Round-robin tie: req0=req1=1 held, data0=5, data1=6, out_ready=1, PRIORITY_MODE=0 -> capture sequence 5,6,5,6 on consecutive cycles, gnt alternating 0,1,0,1, out_valid continuously 1.
- Backpressure: FULL with out_data=5, out_ready=0 for 3 cycles while req1=1, data1=6 -> out_data holds 5, gnt1=0; raising out_ready -> gnt1=1 that cycle, out_data=6 next cycle.
- Fixed priority: PRIORITY_MODE=1, req0=req1=1 for 4 cycles with out_ready=1 -> gnt0=1 every cycle, gnt1 never asserts, out_data=data0 each cycle.
- Reset mid-transfer: FULL with out_ready=0, assert rst_n=0 for one edge -> out_valid=0, last_grant=1 next cycle; after release with req0=req1=1, requester 0 is granted first.
